// File: rtl/lsu_unit.sv
// Load/store unit: one data-memory request/response per load or store, formats load data for write-back.
// Latency: 4 cycles minimum (IDLE->REQ->RESP->DONE), 2 cycles for a misaligned access when LSU_MISALIGN_CHECK_EN is defined.
// Backpressure: request fields held stable until mem_req_ready; stall held until the response arrives.
module lsu_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        is_load,
    input  logic [2:0]        is_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic        load_ok;
    logic        store_ok;
    logic        op_valid;
    logic [2:0]  op_f3;
    logic        misalign;
    logic [3:0]  wmask_n;
    logic [31:0] wdata_n;
    logic        is_ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;

    // Load decode takes priority, so a store code alongside a load is dropped.
    always_comb begin
        load_ok  = 1'b0;
        store_ok = 1'b0;
        case (is_load)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_ok = 1'b1;
            default: ;
        endcase
        case (is_store)
            3'b000, 3'b001, 3'b010: store_ok = 1'b1;
            default: ;
        endcase
        op_valid = load_ok | store_ok;
        op_f3    = load_ok ? is_load : is_store;
    end

    always_comb begin
        wmask_n = 4'b0000;
        wdata_n = 32'h0;
        if (store_ok && !load_ok) begin
            case (is_store[1:0])
                2'b00: begin
                    wmask_n = 4'b0001 << addr[1:0];
                    wdata_n = {4{store_data[7:0]}};
                end
                2'b01: begin
                    wmask_n = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{store_data[15:0]}};
                end
                default: begin
                    wmask_n = 4'b1111;
                    wdata_n = store_data;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((op_f3[1:0] == 2'b01) && addr[0]) ||
                      ((op_f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_fmt = {24'h0, rd_byte};
            3'b101:  rd_fmt = {16'h0, rd_half};
            default: rd_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            is_ld_q   <= 1'b0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
            mem_wdata <= 32'h0;
            load_data <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        is_ld_q <= load_ok;
                        f3_q    <= op_f3;
                        lane_q  <= addr[1:0];
                        if (misalign) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_REQ;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_we    <= ~load_ok;
                            mem_wmask <= wmask_n;
                            mem_wdata <= wdata_n;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) state <= S_RESP;
                end
                S_RESP: begin
                    // Stores treat the response as a write acknowledge only.
                    if (mem_rsp_valid) begin
                        state <= S_DONE;
                        if (is_ld_q) load_data <= rd_fmt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst)                          err_q <= 1'b0;
        else if (state == S_IDLE && op_valid) err_q <= misalign;
    end
    assign err = (state == S_DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_req_valid = (state == S_REQ);
    assign done          = (state == S_DONE);
    assign stall         = ((state == S_IDLE) && op_valid) || (state == S_REQ) || (state == S_RESP);

endmodule
